// File: rtl/pipe_hazard_if.sv
// ID-stage hazard bus: decoded operand/destination info in, pipeline control out.
// master = ID stage / core top, slave = hazard unit.
interface pipe_hazard_if #(
    parameter int STAGES   = 3,
    parameter int REG_BITS = 4,
    parameter int CNT_W    = 16
);
    logic                id_valid;
    logic [REG_BITS-1:0] id_src1;
    logic                id_src1_used;
    logic [REG_BITS-1:0] id_src2;
    logic                id_src2_used;
    logic                id_wb_en;
    logic [REG_BITS-1:0] id_dest;
    logic                id_mem_r_en;
    logic                branch_taken;
    logic                freeze;
    logic                flush;
    logic                bubble;
    logic [STAGES-1:0]   pend_valid;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        output id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
               id_wb_en, id_dest, id_mem_r_en, branch_taken,
        input  freeze, flush, bubble, pend_valid, stall_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
               id_wb_en, id_dest, id_mem_r_en, branch_taken,
        output freeze, flush, bubble, pend_valid, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/control unit: tracks in-flight destinations after ID and
// drives freeze, flush and the ID/EXE bubble strobe.
module pipe_hazard_ctrl #(
    parameter int STAGES   = 3,
    parameter int REG_BITS = 4,
    parameter int FWD_EN   = 0,
    parameter int CNT_W    = 16
) (
    input logic         clk,
    input logic         rst,
    pipe_hazard_if.slave bus
);

    typedef struct packed {
        logic                valid;
        logic                wb_en;
        logic [REG_BITS-1:0] dest;
        logic                mem_r;
    } entry_t;

    entry_t            pend [STAGES];
    logic [STAGES-1:0] hit;
    logic [STAGES-1:0] pend_valid_c;
    logic              hazard;
    logic              freeze_c;
    logic              bubble_c;
    logic [CNT_W-1:0]  stall_cnt_q;

    always_comb begin
        hit          = '0;
        pend_valid_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            pend_valid_c[k] = pend[k].valid;
            hit[k] = pend[k].valid && pend[k].wb_en &&
                     ((bus.id_src1_used && (pend[k].dest == bus.id_src1)) ||
                      (bus.id_src2_used && (pend[k].dest == bus.id_src2)));
        end
    end

    // With forwarding only a load still in EXE cannot supply its result in time.
    always_comb begin
        if (FWD_EN != 0) begin
            hazard = bus.id_valid && hit[0] && pend[0].mem_r;
        end else begin
            hazard = bus.id_valid && (|hit);
        end
        freeze_c = hazard && !bus.branch_taken;
        bubble_c = hazard || bus.branch_taken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                pend[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                pend[k] <= pend[k-1];
            end
            if (bus.id_valid && !bubble_c) begin
                pend[0].valid <= 1'b1;
                pend[0].wb_en <= bus.id_wb_en;
                pend[0].dest  <= bus.id_dest;
                pend[0].mem_r <= bus.id_mem_r_en;
            end else begin
                pend[0] <= '0;
            end
            if (freeze_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.freeze     = freeze_c;
    assign bus.flush      = bus.branch_taken;
    assign bus.bubble     = bubble_c;
    assign bus.pend_valid = pend_valid_c;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: three hazard units (no-forwarding, forwarding, 4-bit counter)
// driven from one linear sequence with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;

    logic       v_valid [3];
    logic [3:0] v_src1  [3];
    logic       v_src1u [3];
    logic [3:0] v_src2  [3];
    logic       v_src2u [3];
    logic       v_wb    [3];
    logic [3:0] v_dest  [3];
    logic       v_mr    [3];
    logic       v_br    [3];

    int n_checks = 0;
    int n_err    = 0;

    pipe_hazard_if #(.STAGES(3), .REG_BITS(4), .CNT_W(16)) bus0 ();
    pipe_hazard_if #(.STAGES(3), .REG_BITS(4), .CNT_W(16)) bus1 ();
    pipe_hazard_if #(.STAGES(3), .REG_BITS(4), .CNT_W(4))  bus2 ();

    pipe_hazard_ctrl #(.STAGES(3), .REG_BITS(4), .FWD_EN(0), .CNT_W(16)) u_nofwd (
        .clk(clk), .rst(rst), .bus(bus0));
    pipe_hazard_ctrl #(.STAGES(3), .REG_BITS(4), .FWD_EN(1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .bus(bus1));
    pipe_hazard_ctrl #(.STAGES(3), .REG_BITS(4), .FWD_EN(0), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .bus(bus2));

    assign bus0.id_valid = v_valid[0];  assign bus1.id_valid = v_valid[1];  assign bus2.id_valid = v_valid[2];
    assign bus0.id_src1  = v_src1[0];   assign bus1.id_src1  = v_src1[1];   assign bus2.id_src1  = v_src1[2];
    assign bus0.id_src1_used = v_src1u[0]; assign bus1.id_src1_used = v_src1u[1]; assign bus2.id_src1_used = v_src1u[2];
    assign bus0.id_src2  = v_src2[0];   assign bus1.id_src2  = v_src2[1];   assign bus2.id_src2  = v_src2[2];
    assign bus0.id_src2_used = v_src2u[0]; assign bus1.id_src2_used = v_src2u[1]; assign bus2.id_src2_used = v_src2u[2];
    assign bus0.id_wb_en = v_wb[0];     assign bus1.id_wb_en = v_wb[1];     assign bus2.id_wb_en = v_wb[2];
    assign bus0.id_dest  = v_dest[0];   assign bus1.id_dest  = v_dest[1];   assign bus2.id_dest  = v_dest[2];
    assign bus0.id_mem_r_en = v_mr[0];  assign bus1.id_mem_r_en = v_mr[1];  assign bus2.id_mem_r_en = v_mr[2];
    assign bus0.branch_taken = v_br[0]; assign bus1.branch_taken = v_br[1]; assign bus2.branch_taken = v_br[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one ID slot of unit d, then let combinational outputs settle.
    task automatic set_id(input int d, input logic vld,
                          input logic [3:0] s1, input logic s1u,
                          input logic [3:0] s2, input logic s2u,
                          input logic wb, input logic [3:0] dst,
                          input logic mr, input logic br);
        v_valid[d] = vld; v_src1[d] = s1; v_src1u[d] = s1u;
        v_src2[d]  = s2;  v_src2u[d] = s2u; v_wb[d] = wb;
        v_dest[d]  = dst; v_mr[d] = mr; v_br[d] = br;
        #1;
    endtask

    task automatic idle(input int d);
        set_id(d, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) idle(d);
        #2;
        chk("rst_pend_valid", bus0.pend_valid, 3'b000);
        chk("rst_stall_cnt", bus0.stall_cnt, 16'd0);
        chk("rst_freeze", bus0.freeze, 1'b0);
        chk("rst_bubble", bus0.bubble, 1'b0);
        chk("rst_flush", bus0.flush, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // ---- no-forwarding RAW: ADD R1,R2,R3 then SUB R2,R1,R4 ----
        set_id(0, 1, 4'd2, 1, 4'd3, 1, 1, 4'd1, 0, 0);
        chk("raw_issue_freeze", bus0.freeze, 1'b0);
        chk("raw_issue_bubble", bus0.bubble, 1'b0);
        tick();
        set_id(0, 1, 4'd1, 1, 4'd4, 1, 1, 4'd2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("raw_stall_freeze", bus0.freeze, 1'b1);
            chk("raw_stall_bubble", bus0.bubble, 1'b1);
            chk("raw_stall_pend", bus0.pend_valid, 32'd1 << i);
            tick();
        end
        chk("raw_release_freeze", bus0.freeze, 1'b0);
        chk("raw_release_bubble", bus0.bubble, 1'b0);
        chk("raw_release_pend", bus0.pend_valid, 3'b000);
        chk("raw_stall_cnt", bus0.stall_cnt, 16'd3);
        tick();
        chk("raw_issued_pend", bus0.pend_valid, 3'b001);

        // R2 pending in entry 0 but src1 not read
        set_id(0, 1, 4'd2, 0, 4'd5, 1, 1, 4'd6, 0, 0);
        chk("unused_src_freeze", bus0.freeze, 1'b0);
        tick();
        // non-writing producer of R7 (compare-like)
        set_id(0, 1, 4'd8, 1, 4'd9, 1, 0, 4'd7, 0, 0);
        chk("nowb_issue_freeze", bus0.freeze, 1'b0);
        tick();
        set_id(0, 1, 4'd7, 1, 4'd0, 0, 0, 4'd0, 0, 0);
        chk("nowb_consumer_freeze", bus0.freeze, 1'b0);
        chk("nowb_consumer_bubble", bus0.bubble, 1'b0);
        tick();
        idle(0);
        tick(); tick(); tick();
        chk("drain_pend", bus0.pend_valid, 3'b000);
        chk("drain_stall_cnt", bus0.stall_cnt, 16'd3);

        // ---- branch over hazard, then back-to-back branches ----
        set_id(0, 1, 4'd0, 0, 4'd0, 0, 1, 4'd1, 0, 0);
        tick();
        set_id(0, 0, 4'd1, 1, 4'd0, 0, 1, 4'd2, 0, 0);
        chk("invalid_id_freeze", bus0.freeze, 1'b0);
        chk("invalid_id_bubble", bus0.bubble, 1'b0);
        set_id(0, 1, 4'd1, 1, 4'd0, 0, 1, 4'd2, 0, 1);
        chk("br_hz_flush", bus0.flush, 1'b1);
        chk("br_hz_bubble", bus0.bubble, 1'b1);
        chk("br_hz_freeze", bus0.freeze, 1'b0);
        tick();
        chk("br_hz_entry0_dropped", bus0.pend_valid, 3'b010);
        set_id(0, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1);
        chk("br2_flush", bus0.flush, 1'b1);
        chk("br2_bubble", bus0.bubble, 1'b1);
        chk("br2_freeze", bus0.freeze, 1'b0);
        tick();
        chk("br3_flush", bus0.flush, 1'b1);
        tick();
        chk("br_done_pend", bus0.pend_valid, 3'b000);
        idle(0);
        chk("br_done_flush", bus0.flush, 1'b0);
        chk("br_stall_cnt", bus0.stall_cnt, 16'd3);

        // ---- forwarding: load-use stalls once, ALU producer never ----
        set_id(1, 1, 4'd1, 1, 4'd0, 0, 1, 4'd3, 1, 0);
        chk("fwd_ldr_freeze", bus1.freeze, 1'b0);
        tick();
        set_id(1, 1, 4'd3, 1, 4'd5, 1, 1, 4'd4, 0, 0);
        chk("fwd_loaduse_freeze", bus1.freeze, 1'b1);
        chk("fwd_loaduse_bubble", bus1.bubble, 1'b1);
        tick();
        chk("fwd_loaduse_release", bus1.freeze, 1'b0);
        chk("fwd_loaduse_pend", bus1.pend_valid, 3'b010);
        tick();
        set_id(1, 1, 4'd4, 1, 4'd0, 0, 1, 4'd3, 0, 0);
        chk("fwd_alu_dep_freeze", bus1.freeze, 1'b0);
        tick();
        set_id(1, 1, 4'd0, 0, 4'd3, 1, 1, 4'd5, 0, 0);
        chk("fwd_alu_r3_freeze", bus1.freeze, 1'b0);
        tick();
        set_id(1, 1, 4'd2, 1, 4'd0, 0, 1, 4'd9, 1, 0);
        tick();
        set_id(1, 1, 4'd1, 1, 4'd9, 1, 0, 4'd0, 0, 0);
        chk("fwd_store_src2_freeze", bus1.freeze, 1'b1);
        tick();
        chk("fwd_store_release", bus1.freeze, 1'b0);
        tick();
        idle(1);
        chk("fwd_stall_cnt", bus1.stall_cnt, 16'd2);

        // ---- saturation: ADD R1,R1 repeated, 3 freezes per 4 cycles ----
        set_id(2, 1, 4'd1, 1, 4'd0, 0, 1, 4'd1, 0, 0);
        for (int i = 0; i < 28; i++) begin
            chk("sat_freeze", bus2.freeze, ((i % 4) != 0) ? 1'b1 : 1'b0);
            tick();
            if (i == 15) chk("sat_cnt_mid", bus2.stall_cnt, 4'd12);
        end
        chk("sat_cnt_final", bus2.stall_cnt, 4'd15);
        idle(2);

        // ---- asynchronous reset mid-stall with all entries full (R0 match) ----
        set_id(0, 1, 4'd0, 0, 4'd0, 0, 1, 4'd10, 0, 0);
        tick();
        set_id(0, 1, 4'd0, 0, 4'd0, 0, 1, 4'd11, 0, 0);
        tick();
        set_id(0, 1, 4'd0, 0, 4'd0, 0, 1, 4'd0, 0, 0);
        tick();
        set_id(0, 1, 4'd6, 0, 4'd0, 1, 1, 4'd3, 0, 0);
        chk("full_pend", bus0.pend_valid, 3'b111);
        chk("r0_freeze", bus0.freeze, 1'b1);
        tick();
        chk("r0_freeze_hold", bus0.freeze, 1'b1);
        chk("pre_rst_stall_cnt", bus0.stall_cnt, 16'd4);
        rst = 1'b1;
        #1;
        chk("arst_pend", bus0.pend_valid, 3'b000);
        chk("arst_freeze", bus0.freeze, 1'b0);
        chk("arst_bubble", bus0.bubble, 1'b0);
        chk("arst_flush", bus0.flush, 1'b0);
        chk("arst_stall_cnt", bus0.stall_cnt, 16'd0);
        chk("arst_sat_cnt", bus2.stall_cnt, 4'd0);
        chk("arst_fwd_cnt", bus1.stall_cnt, 16'd0);
        #1 rst = 1'b0;
        idle(0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard and control unit for the ARM core. It tracks in-flight destination registers for the stages after ID. It drives the pipeline `freeze` and `flush` signals and a bubble-insert strobe into the ID/EXE register. These replace the constant-zero freeze/flush/branch wiring in the core top. It supports no-forwarding mode (stall on any RAW) and forwarding mode (stall on load-use only).

## Interface
Parameters:
- `STAGES`, 3, number of tracked stages after ID (entry 0 = EXE, entry STAGES-1 = last before regfile write); range 1..8
- `REG_BITS`, 4, register-index width (16 architectural registers)
- `FWD_EN`, 0, 0 = stall on any RAW against any tracked entry; 1 = stall only on load-use against entry 0
- `CNT_W`, 16, stall-counter width

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `id_valid`  in  1  ID holds a valid decoded instruction
- `id_src1`  in  REG_BITS  Rn index
- `id_src1_used`  in  1  instruction reads Rn
- `id_src2`  in  REG_BITS  Rm/Rd-for-store index
- `id_src2_used`  in  1  instruction reads src2
- `id_wb_en`  in  1  instruction writes a register
- `id_dest`  in  REG_BITS  destination index
- `id_mem_r_en`  in  1  instruction is a load
- `branch_taken`  in  1  branch in EXE (entry 0) resolved taken this cycle
- `freeze`  out  1  hold PC, IF/ID register
- `flush`  out  1  clear IF/ID register
- `bubble`  out  1  load NOP into ID/EXE register
- `pend_valid`  out  STAGES  valid bit of each tracked entry
- `stall_cnt`  out  CNT_W  saturating count of freeze cycles

## Operation
- State: shift register of STAGES entries {valid, wb_en, dest, mem_r}.
- Match k,s: entry[k].valid && entry[k].wb_en && id_src_s_used && entry[k].dest == id_src_s.
- hazard (FWD_EN=0): id_valid && any match over k = 0..STAGES-1, s = 1,2.
- hazard (FWD_EN=1): id_valid && (match 0,1 || match 0,2) && entry[0].mem_r.
- Outputs, combinational from state and inputs:
  - flush = branch_taken.
  - freeze = hazard && !branch_taken (a branch overrides the stall; IF must load the target).
  - bubble = hazard || branch_taken.
- Clock edge:
  - entry[k] <= entry[k-1] for k ≥ 1.
  - entry[0] <= {1, id_wb_en, id_dest, id_mem_r_en} if id_valid && !bubble, else all-zero.
- stall_cnt: increments on each cycle with freeze=1; holds at 2^CNT_W−1.
- pend_valid[k] = entry[k].valid.
- id_valid=0: no hazard, entry[0] becomes invalid, bubble=0 unless branch_taken.
- Register index equality is full-width; no special-casing of any index.

## Timing
- Reset (asynchronous): all entries cleared, stall_cnt=0. freeze, flush, bubble and pend_valid drop to 0 immediately (flush follows branch_taken combinationally). This holds mid-stall as well.
- Same-cycle combinational path from id_* and branch_taken to freeze, flush and bubble. No registered latency on control outputs.
- Each entry lives exactly STAGES cycles after issue.
- FWD_EN=0: producer issued in cycle t. A dependent instruction in ID at t+1 is frozen for cycles t+1..t+STAGES and issues at t+STAGES+1.
- FWD_EN=1, load issued at t: dependent instruction is frozen at t+1 only and issues at t+2. A dependent ALU producer causes no stall.
- Simultaneous hazard and branch_taken: flush=1, bubble=1, freeze=0. The ID instruction is discarded and never recorded.
- Back-to-back branch_taken: each cycle flushes independently.

## Test plan
- Reset: assert rst mid-stall with entries full. Required: pend_valid=0, freeze=0 and stall_cnt=0 within the same cycle, with no clock edge needed.
- RAW, FWD_EN=0, STAGES=3: issue ADD R1 at t, then SUB R2,R1 in ID. Required: freeze=bubble=1 for 3 cycles (t+1..t+3), issue at t+4, stall_cnt=3.
- Load-use, FWD_EN=1: LDR R3 at t, then ADD R4,R3. Required: freeze=1 for exactly 1 cycle. Same sequence with an ADD R3 producer: no freeze.
- Branch over hazard: a hazard is present and branch_taken=1 in the same cycle. Required: flush=1, bubble=1, freeze=0, and entry[0] invalid next cycle.
- Unused source: id_src1=R1 with id_src1_used=0, and R1 pending. Required: no freeze. Also cover id_wb_en=0 producers, which must never cause a stall.
- Saturation, CNT_W=4: hold a hazard for 20 cycles. Required: stall_cnt stops at 15.
